// File: rtl/spdot_pkg.sv
// rtl/spdot_pkg.sv - shared types, constants and lane-sum helper for the BSR score engine
package spdot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX,
    S_IDXW,
    S_MAC,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } state_e;

  localparam logic [15:0] IDX_EMPTY = 16'hFFFF;
  localparam int MAX_LANES = 16;

  // Each 64-bit slot holds a pw-bit signed product in its low bits; slots at or above lanes are ignored.
  function automatic logic signed [63:0] sum_lanes(input logic [MAX_LANES*64-1:0] prods,
                                                   input int lanes, input int pw);
    logic [63:0]        p;
    logic signed [63:0] s;
    logic signed [63:0] tot;
    tot = '0;
    for (int l = 0; l < MAX_LANES; l++) begin
      p = prods[l*64 +: 64];
      s = $signed(p << (64 - pw)) >>> (64 - pw);
      if (l < lanes) tot = tot + s;
    end
    return tot;
  endfunction

endpackage

// File: rtl/spdot_lane_mac.sv
// rtl/spdot_lane_mac.sv - combinational LANES-wide signed multiply and adder tree
module spdot_lane_mac import spdot_pkg::*; #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 48
) (
  input  logic [LANES*DW-1:0]     a,
  input  logic [LANES*DW-1:0]     b,
  output logic signed [ACC_W-1:0] sum
);

  logic [MAX_LANES*64-1:0] prods;
  logic signed [2*DW-1:0]  ea;
  logic signed [2*DW-1:0]  eb;

  always_comb begin
    prods = '0;
    ea    = '0;
    eb    = '0;
    for (int l = 0; l < LANES; l++) begin
      ea = (2*DW)'($signed(a[l*DW +: DW]));
      eb = (2*DW)'($signed(b[l*DW +: DW]));
      prods[l*64 +: 2*DW] = ea * eb;
    end
  end

  assign sum = ACC_W'(sum_lanes(prods, LANES, 2*DW));

endmodule

// File: rtl/spdot_bsr_lane_core.sv
// rtl/spdot_bsr_lane_core.sv - block-sparse Q.K^T score engine: index walk, MAC, score stream, checksum
module spdot_bsr_lane_core import spdot_pkg::*; #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 48,
  parameter int AW    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [15:0]             m_rows,
  input  logic [15:0]             head_dim_d,
  input  logic [15:0]             block_size,
  input  logic [15:0]             blks_per_row,
  output logic [AW-1:0]           q_raddr,
  output logic [AW-1:0]           k_raddr,
  input  logic [LANES*DW-1:0]     q_rdata,
  input  logic [LANES*DW-1:0]     k_rdata,
  output logic [AW-1:0]           idx_rd_addr,
  input  logic [15:0]             idx_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_row,
  output logic [15:0]             out_tok,
  output logic signed [ACC_W-1:0] out_score,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [63:0]             checksum_out
);

  state_e                  state;
  logic [15:0]             cfg_m, cfg_bs, cfg_bpr, w;
  logic [15:0]             i, b, t, k;
  logic [31:0]             tok;
  logic                    pend;
  logic signed [ACC_W-1:0] acc, mac, acc_sum;
  logic [63:0]             csum, csum_add;
  logic [15:0]             nxt_i, nxt_b;
  logic                    last_slot;
  logic [AW-1:0]           nxt_idx;

  spdot_lane_mac #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) u_mac (
    .a   (q_rdata),
    .b   (k_rdata),
    .sum (mac)
  );

  assign acc_sum  = acc + mac;
  assign csum_add = csum + 64'($signed(out_score));

  // Slot successor: next block in this row, else first block of the next row.
  always_comb begin
    nxt_i     = i;
    nxt_b     = b + 16'd1;
    last_slot = 1'b0;
    if (32'(b) + 32'd1 >= 32'(cfg_bpr)) begin
      nxt_b     = '0;
      nxt_i     = i + 16'd1;
      last_slot = (32'(i) + 32'd1 >= 32'(cfg_m));
    end
  end

  assign nxt_idx = AW'(32'(nxt_i) * 32'(cfg_bpr) + 32'(nxt_b));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cfg_m        <= '0;
      cfg_bs       <= '0;
      cfg_bpr      <= '0;
      w            <= '0;
      i            <= '0;
      b            <= '0;
      t            <= '0;
      k            <= '0;
      tok          <= '0;
      pend         <= 1'b0;
      acc          <= '0;
      csum         <= '0;
      q_raddr      <= '0;
      k_raddr      <= '0;
      idx_rd_addr  <= '0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_tok      <= '0;
      out_score    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      checksum_out <= '0;
    end else begin
      pend <= (state == S_MAC);
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_m        <= m_rows;
            cfg_bs       <= block_size;
            cfg_bpr      <= blks_per_row;
            w            <= 16'(32'(head_dim_d) / LANES);
            i            <= '0;
            b            <= '0;
            acc          <= '0;
            csum         <= '0;
            err          <= 1'b0;
            checksum_out <= '0;
            if (block_size == 16'd0 || (32'(head_dim_d) % LANES) != 0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (m_rows == 16'd0 || blks_per_row == 16'd0 || head_dim_d == 16'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy        <= 1'b1;
              idx_rd_addr <= '0;
              state       <= S_IDX;
            end
          end
        end
        S_IDX: state <= S_IDXW;
        S_IDXW: begin
          if (idx_rd_data == IDX_EMPTY) begin
            i <= nxt_i;
            b <= nxt_b;
            if (last_slot) begin
              busy         <= 1'b0;
              done         <= 1'b1;
              checksum_out <= csum;
              state        <= S_DONE;
            end else begin
              idx_rd_addr <= nxt_idx;
              state       <= S_IDX;
            end
          end else begin
            t       <= '0;
            k       <= '0;
            tok     <= 32'(idx_rd_data) * 32'(cfg_bs);
            q_raddr <= AW'(32'(i) * 32'(w));
            k_raddr <= AW'(32'(idx_rd_data) * 32'(cfg_bs) * 32'(w));
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          // Data for the word issued last cycle is on the read ports now.
          if (pend) acc <= acc_sum;
          if (32'(k) + 32'd1 < 32'(w)) begin
            k       <= k + 16'd1;
            q_raddr <= AW'(32'(i) * 32'(w) + 32'(k) + 32'd1);
            k_raddr <= AW'(tok * 32'(w) + 32'(k) + 32'd1);
          end else begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          acc       <= acc_sum;
          out_score <= acc_sum;
          out_row   <= i;
          out_tok   <= tok[15:0];
          out_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            csum      <= csum_add;
            acc       <= '0;
            if (32'(t) + 32'd1 < 32'(cfg_bs)) begin
              t       <= t + 16'd1;
              tok     <= tok + 32'd1;
              k       <= '0;
              q_raddr <= AW'(32'(i) * 32'(w));
              k_raddr <= AW'((tok + 32'd1) * 32'(w));
              state   <= S_MAC;
            end else begin
              i <= nxt_i;
              b <= nxt_b;
              if (last_slot) begin
                busy         <= 1'b0;
                done         <= 1'b1;
                checksum_out <= csum_add;
                state        <= S_DONE;
              end else begin
                idx_rd_addr <= nxt_idx;
                state       <= S_IDX;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spdot_bsr_lane_core.sv
// tb/tb_spdot_bsr_lane_core.sv - self-checking bench with behavioural score model and random stimulus
module tb_spdot_bsr_lane_core;
  localparam int LANES = 4, DW = 16, ACC_W = 48, AW = 16;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [15:0] m_rows = '0, head_dim_d = '0, block_size = '0, blks_per_row = '0;
  logic [AW-1:0] q_raddr, k_raddr, idx_rd_addr;
  logic [63:0] q_rdata = '0, k_rdata = '0;
  logic [15:0] idx_rd_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [15:0] out_row, out_tok;
  logic signed [ACC_W-1:0] out_score;
  logic busy, done, err;
  logic [63:0] checksum_out;

  spdot_bsr_lane_core #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .m_rows(m_rows), .head_dim_d(head_dim_d), .block_size(block_size), .blks_per_row(blks_per_row),
    .q_raddr(q_raddr), .k_raddr(k_raddr), .q_rdata(q_rdata), .k_rdata(k_rdata),
    .idx_rd_addr(idx_rd_addr), .idx_rd_data(idx_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_tok(out_tok),
    .out_score(out_score), .busy(busy), .done(done), .err(err), .checksum_out(checksum_out)
  );

  always #5 clk = ~clk;

  logic [63:0] qmem [0:65535];
  logic [63:0] kmem [0:65535];
  logic [15:0] imem [0:65535];

  always @(posedge clk) begin
    q_rdata     <= qmem[q_raddr];
    k_rdata     <= kmem[k_raddr];
    idx_rd_data <= imem[idx_rd_addr];
  end

  int checks = 0, errors = 0, done_cnt = 0, ready_mode = 0, scnt = 0;

  typedef struct {int row; int tok; longint score;} exp_t;
  exp_t   exp_q[$];
  exp_t   e;
  longint exp_sum;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic longint lane(input logic [63:0] wd, input int l);
    logic signed [15:0] v;
    v = wd[l*16 +: 16];
    return longint'(v);
  endfunction

  // Reference: walk every row/slot/token and form the dot product directly from memory.
  task automatic build_model(input int m, input int hd, input int bs, input int bpr);
    int wn;
    longint j, s;
    logic [15:0] c;
    exp_t x;
    exp_q.delete();
    exp_sum = 0;
    if (bs == 0 || hd % LANES != 0 || m == 0 || bpr == 0 || hd == 0) return;
    wn = hd / LANES;
    for (int ri = 0; ri < m; ri++)
      for (int bi = 0; bi < bpr; bi++) begin
        c = imem[(ri * bpr + bi) % 65536];
        if (c == 16'hFFFF) continue;
        for (int ti = 0; ti < bs; ti++) begin
          j = longint'(c) * bs + ti;
          s = 0;
          for (int kk = 0; kk < wn; kk++)
            for (int l = 0; l < LANES; l++)
              s += lane(qmem[(ri * wn + kk) % 65536], l) * lane(kmem[(j * wn + kk) % 65536], l);
          x.row = ri; x.tok = int'(j % 65536); x.score = s;
          exp_q.push_back(x);
          exp_sum += s;
        end
      end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && scnt < 5) begin out_ready = 1'b0; scnt++; end
        else begin out_ready = 1'b1; if (out_valid) scnt = 0; end
      end
    endcase
  end

  logic stalled = 1'b0;
  logic [15:0] h_row, h_tok;
  logic [ACC_W-1:0] h_score;
  logic [AW-1:0] h_q, h_k;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (stalled && rstn)
      chk("stall_hold", longint'(out_valid && out_row == h_row && out_tok == h_tok &&
          out_score == h_score && q_raddr == h_q && k_raddr == h_k), 1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_row", longint'(out_row), e.row);
        chk("out_tok", longint'(out_tok), e.tok);
        chk("out_score", longint'(out_score), e.score);
      end
    end
    stalled = out_valid && !out_ready;
    h_row = out_row; h_tok = out_tok; h_score = out_score; h_q = q_raddr; h_k = k_raddr;
  end

  task automatic launch(input int m, input int hd, input int bs, input int bpr);
    @(posedge clk); #1;
    m_rows = 16'(m); head_dim_d = 16'(hd); block_size = 16'(bs); blks_per_row = 16'(bpr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int m, input int hd, input int bs, input int bpr,
                     input bit exp_err, input bit quick, input bit poke);
    int cyc;
    bit seen;
    seen = 0;
    launch(m, hd, bs, bpr);
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && !quick) chk({tag, "_busy"}, longint'(busy), 1);
      if (poke && cyc == 3) begin start = 1'b1; m_rows = 16'd7; end
      if (poke && cyc == 4) start = 1'b0;
      if (done) begin seen = 1; break; end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, longint'(seen), 1);
    if (quick) chk({tag, "_done_latency"}, cyc, 0);
    chk({tag, "_err"}, longint'(err), longint'(exp_err));
    chk({tag, "_checksum"}, longint'(checksum_out), exp_sum);
    chk({tag, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, longint'({done, busy}), 0);
  endtask

  function automatic bit all_zero();
    return q_raddr == '0 && k_raddr == '0 && idx_rd_addr == '0 && !out_valid && out_row == '0 &&
           out_tok == '0 && out_score == '0 && !busy && !done && !err && checksum_out == '0;
  endfunction

  int toks[6] = '{2, 3, 0, 1, 6, 7};
  int rows[6] = '{0, 0, 1, 1, 1, 1};
  longint cs3;
  int dc, m, bpr, bs, hd, r;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      qmem[a] = {$urandom, $urandom};
      kmem[a] = {$urandom, $urandom};
      imem[a] = 16'hFFFF;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", longint'(all_zero()), 1);
    #1 rstn = 1'b1;

    imem[0] = 16'd0;
    qmem[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    kmem[0] = {16'd8, 16'd7, 16'd6, 16'd5};
    build_model(1, 4, 1, 1);
    chk("model_t1", exp_sum, 70);
    run("t1", 1, 4, 1, 1, 0, 0, 0);
    chk("t1_cs_lit", longint'(checksum_out), 70);

    qmem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    kmem[0] = 64'h0003_0003_0003_0003;
    build_model(1, 4, 1, 1);
    run("t2", 1, 4, 1, 1, 0, 0, 0);
    chk("t2_cs_lit", longint'(checksum_out), longint'(64'hFFFF_FFFF_FFFF_FFF4));

    imem[0] = 16'd1; imem[1] = 16'hFFFF; imem[2] = 16'd0; imem[3] = 16'd3;
    build_model(2, 8, 2, 2);
    chk("model_t3_count", exp_q.size(), 6);
    for (int n = 0; n < 6; n++) begin
      chk("model_t3_tok", exp_q[n].tok, toks[n]);
      chk("model_t3_row", exp_q[n].row, rows[n]);
    end
    cs3 = exp_sum;
    run("t3", 2, 8, 2, 2, 0, 0, 0);

    ready_mode = 2;
    build_model(2, 8, 2, 2);
    run("t4_stall", 2, 8, 2, 2, 0, 0, 0);
    chk("t4_same_as_nostall", longint'(checksum_out), cs3);
    ready_mode = 0;

    build_model(1, 4, 0, 1);
    run("bs0", 1, 4, 0, 1, 1, 1, 0);
    build_model(1, 6, 1, 1);
    run("hd6", 1, 6, 1, 1, 1, 1, 0);
    build_model(0, 4, 1, 1);
    run("m0", 0, 4, 1, 1, 0, 1, 0);
    build_model(1, 0, 1, 1);
    run("hd0", 1, 0, 1, 1, 0, 1, 0);

    imem[0] = 16'd0;
    dc = done_cnt;
    launch(1, 16, 1, 1);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_reset_zero", longint'(all_zero()), 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("start_in_reset_dropped", longint'(busy), 0);
    chk("midrun_no_done", done_cnt, dc);
    build_model(1, 16, 1, 1);
    run("after_reset", 1, 16, 1, 1, 0, 0, 0);

    ready_mode = 1;
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(1, 3); bpr = $urandom_range(1, 3);
      bs = $urandom_range(1, 3); hd = 4 * $urandom_range(1, 3);
      for (int s = 0; s < m * bpr; s++) begin
        r = $urandom_range(0, 9);
        if (r < 2) imem[s] = 16'hFFFF;
        else if (r < 4) imem[s] = 16'($urandom_range(16'hFF00, 16'hFFFE));
        else imem[s] = 16'($urandom_range(0, 7));
      end
      build_model(m, hd, bs, bpr);
      run("rand", m, hd, bs, bpr, 0, 0, it == 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/spdot_bsr_lane_core.md
# spdot_bsr_lane_core

Parametrised block-sparse (BSR) Q·Kᵀ score engine. For each query row it reads the row's non-zero column-block ids from index RAM, then fetches real Q/K vectors from the scratchpads. It computes LANES-wide signed MAC dot products over head_dim, streams one score per (row, token) under valid/ready, and folds all scores into a 64-bit checksum. It sits under the accelerator top-level, sharing the scratchpad and index-RAM read muxes.

## Interface
- LANES, 4: elements per scratchpad word / MACs per cycle
- DW, 16: signed element width
- ACC_W, 48: accumulator/score width (≥ 2·DW + clog2(max head_dim))
- AW, 16: scratchpad and index address width
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  single-cycle launch; ignored unless idle
- m_rows, head_dim_d, block_size, blks_per_row  in  16 each  config, sampled on start
- q_raddr, k_raddr  out  AW  word addresses
- q_rdata, k_rdata  in  LANES·DW  packed signed lanes, lane 0 in LSBs; 1-cycle read latency
- idx_rd_addr  out  AW;  idx_rd_data  in  16  column-block id, 16'hFFFF = empty slot
- out_valid  out  1;  out_ready  in  1
- out_row, out_tok  out  16;  out_score  out  ACC_W signed
- busy, done, err  out  1;  checksum_out  out  64

## Operation
- Config is latched on accepted start. W = head_dim_d / LANES words per vector.
- err is set, and the core goes straight to DONE with checksum 0, if block_size == 0 or head_dim_d % LANES != 0.
- If m_rows, blks_per_row or head_dim_d is 0, the core goes to DONE with checksum 0 and err = 0.
- States: IDLE → IDX → IDXW → MAC → DRAIN → EMIT → (MAC | IDX | DONE) → IDLE.
- IDX: drive idx_rd_addr = i·blks_per_row + b.
- IDXW: capture c = idx_rd_data.
  - If c == FFFF, skip the slot: b++, go to IDX or, after the last slot of the last row, DONE.
  - Otherwise t = 0 and go to MAC.
- MAC, with token j = c·block_size + t:
  - Issue q_raddr = i·W + k and k_raddr = j·W + k for k = 0..W-1, one per cycle.
  - Data returning the next cycle is sign-extended per lane, multiplied, summed across lanes, and added to acc.
- DRAIN: absorbs the final returning word.
- EMIT: out_score = acc, out_row = i, out_tok = j[15:0].
  - On handshake: checksum += sign-extended score (mod 2^64), acc cleared, t++.
  - If t < block_size, go to MAC; else b++, then next slot, next row, or DONE.
- DONE lasts exactly 1 cycle: done = 1, checksum_out is updated, busy = 0.
- checksum_out holds its value until the next accepted start, which clears it to 0.
- Address arithmetic is computed at 32 bits and truncated to AW, so wrap is modulo 2^AW.
- Token ids ≥ 2^16 truncate on out_tok only.

## Timing
- Reset (rstn = 0 at a clk edge) sets state to IDLE and clears all outputs and registers to 0. This includes addresses, out_*, err and checksum.
- Reset mid-run aborts with no done pulse.
- busy = 1 in every state except IDLE and DONE.
- Per non-empty token: W + 1 cycles of MAC/DRAIN + ≥1 EMIT.
- Per slot: 2 cycles of IDX/IDXW.
- Empty slot: 2 cycles, no output.
- out_valid is asserted in EMIT only. out_* hold stable while out_valid && !out_ready.
- No reads are issued while stalled; q/k addresses hold.
- start during busy or DONE is ignored. start in the same cycle as reset is dropped.
- Zero-work/err runs reach DONE 1 cycle after start (done high in cycle start+1).

## Structure
- Package spdot_pkg holds:
  - the state_e enum
  - the IDX_EMPTY = 16'hFFFF constant
  - a function to sign-extend and sum LANES products
- One sub-module, spdot_lane_mac: combinational LANES × DW signed products plus adder tree, giving ACC_W out.
- The FSM, counters (i, b, t, k), acc and checksum live in the core.

## Test plan
- LANES=4, head_dim=4, block_size=1, m_rows=1, blks_per_row=1, idx={0}, Q word={1,2,3,4}, K={5,6,7,8} → one output (0,0,70); checksum 70; done exactly 1 cycle.
- Signed lanes: Q={-1,-1,-1,-1}, K={3,3,3,3} → score −12; checksum 0xFFFF_FFFF_FFFF_FFF4.
- m_rows=2, blks_per_row=2, block_size=2, idx={1,FFFF,0,3}, head_dim=8 → tokens (0,2),(0,3),(1,0),(1,1),(1,6),(1,7) in order; each scored against the correct Q row/K word pairs.
- Backpressure: out_ready low 5 cycles in EMIT → out_* stable, addresses frozen, results identical to no-stall run.
- block_size=0 → err=1, done 1 cycle after start, checksum_out=0; head_dim=6 with LANES=4 → same.
- Reset asserted mid-MAC → next cycle all outputs 0, IDLE; a following start runs cleanly with the correct checksum.
